// File: rtl/pool2x2_stream.sv
// pool2x2_stream
// 2x2, stride-2 pooling over a row-major pixel stream. Each beat carries CH
// signed DW-bit channels. The block emits one pooled pixel per 2x2 window,
// using either max or floor-average pooling.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         pooling enable; low clears counters and hold register
//   mode       0 = max pooling, 1 = average pooling
//   col        columns per input row (even, 2..MAX_COL)
//   rows       rows per input frame (even, >= 2)
//   valid_in   data_in carries a pixel this cycle
//   data_in    input pixel, channel c at [c*DW +: DW]
//   data_out   pooled pixel, same packing; holds until the next valid_out
//   valid_out  one-cycle pulse per pooled pixel
//   pool_end   one-cycle pulse with the last valid_out of a frame
module pool2x2_stream #(
  parameter int CH      = 12,
  parameter int DW      = 8,
  parameter int MAX_COL = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [15:0]      col,
  input  logic [15:0]      rows,
  input  logic             valid_in,
  input  logic [CH*DW-1:0] data_in,
  output logic [CH*DW-1:0] data_out,
  output logic             valid_out,
  output logic             pool_end
);

  localparam int LB_DEPTH = MAX_COL / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int EW       = DW + 2;  // line-buffer width per channel

  logic [15:0]        col_cnt;
  logic [15:0]        row_cnt;
  logic [CH*DW-1:0]   hold_q;
  logic [CH*EW-1:0]   line_buf [LB_DEPTH];
  logic [CH*EW-1:0]   lb_rd;
  logic [CH*EW-1:0]   pair_bus;
  logic [CH*DW-1:0]   res_bus;
  logic [AW-1:0]      lb_addr;
  logic               last_col;
  logic               last_row;
  logic               beat;

  // Greater-or-equal compares keep the counters wrapping even if the
  // geometry changes mid-frame.
  assign last_col = (col_cnt >= (col - 16'd1));
  assign last_row = (row_cnt >= (rows - 16'd1));
  assign beat     = en && valid_in;
  assign lb_addr  = col_cnt[AW:1];
  assign lb_rd    = line_buf[lb_addr];

  // Per-channel datapath: horizontal pair, then vertical combine with the
  // line-buffer entry written on the even row above.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DW-1:0] cur;
    logic signed [DW-1:0] hld;
    logic signed [DW-1:0] hmax;
    logic signed [EW-1:0] pair;
    logic signed [EW-1:0] lb;

    assign cur  = data_in[c*DW +: DW];
    assign hld  = hold_q[c*DW +: DW];
    assign hmax = (cur > hld) ? cur : hld;
    // Max results are sign-extended so the vertical compare works at full
    // width; avg results are the (DW+1)-bit pair sum.
    assign pair = mode ? ({{2{cur[DW-1]}}, cur} + {{2{hld[DW-1]}}, hld})
                       : {{2{hmax[DW-1]}}, hmax};
    assign lb   = lb_rd[c*EW +: EW];

    assign pair_bus[c*EW +: EW] = pair;
    // Arithmetic shift of the 4-term sum is floor division; the quotient
    // always fits DW bits.
    assign res_bus[c*DW +: DW]  = mode ? DW'((pair + lb) >>> 2)
                                       : DW'((pair > lb) ? pair : lb);
  end

  // Counters, hold register and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      hold_q    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      pool_end  <= 1'b0;
    end else if (!en) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      hold_q    <= '0;
      valid_out <= 1'b0;
      pool_end  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      pool_end  <= 1'b0;
      if (valid_in) begin
        if (!col_cnt[0]) hold_q <= data_in;

        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? 16'd0 : row_cnt + 16'd1;
        end else begin
          col_cnt <= col_cnt + 16'd1;
        end

        if (col_cnt[0] && row_cnt[0]) begin
          data_out  <= res_bus;
          valid_out <= 1'b1;
          pool_end  <= last_row && last_col;
        end
      end
    end
  end

  // Line buffer: written on odd columns of even rows, read on odd columns
  // of odd rows, so one address is never read and written in the same cycle.
  // NOTE: the line buffer has no reset; every entry is rewritten by an even
  // row before an odd row reads it, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (rst_n && beat && col_cnt[0] && !row_cnt[0]) begin
      line_buf[lb_addr] <= pair_bus;
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Self-checking bench for pool2x2_stream: a driver pushes expected pooled
// pixels into a scoreboard queue as windows complete; a monitor pops and
// compares whenever valid_out is seen.
module tb_pool2x2_stream;

  localparam int CH      = 12;
  localparam int DW      = 8;
  localparam int MAX_COL = 64;
  localparam int PMAX    = 16;

  typedef struct {
    logic [CH*DW-1:0] data;
    logic             pend;
    longint           cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             mode;
  logic [15:0]      col;
  logic [15:0]      rows;
  logic             valid_in;
  logic [CH*DW-1:0] data_in;
  logic [CH*DW-1:0] data_out;
  logic             valid_out;
  logic             pool_end;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  exp_t   sb[$];
  int     pix [PMAX][PMAX][CH];

  pool2x2_stream #(.CH(CH), .DW(DW), .MAX_COL(MAX_COL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .col(col), .rows(rows),
    .valid_in(valid_in), .data_in(data_in), .data_out(data_out),
    .valid_out(valid_out), .pool_end(pool_end)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: pooling of window (i,j) straight from the pixel array.
  function automatic logic [CH*DW-1:0] pool_ref(int i, int j, bit m);
    logic [CH*DW-1:0] r;
    int a, b, d, e, v, s;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      a = pix[2*i][2*j][c];
      b = pix[2*i][2*j+1][c];
      d = pix[2*i+1][2*j][c];
      e = pix[2*i+1][2*j+1][c];
      if (m) begin
        s = a + b + d + e;
        v = (s - (((s % 4) + 4) % 4)) / 4;  // floor division
      end else begin
        v = a;
        if (b > v) v = b;
        if (d > v) v = d;
        if (e > v) v = e;
      end
      r[c*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic void fill_random(int nr, int nc);
    for (int r = 0; r < nr; r++)
      for (int k = 0; k < nc; k++)
        for (int c = 0; c < CH; c++)
          pix[r][k][c] = int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic void fill_ramp(int nr, int nc);
    for (int r = 0; r < nr; r++)
      for (int k = 0; k < nc; k++)
        for (int c = 0; c < CH; c++)
          pix[r][k][c] = (r * 16 + k + c) % 128;
  endfunction

  function automatic void fill_window(int i, int j, int v0, int v1, int v2, int v3);
    for (int c = 0; c < CH; c++) begin
      pix[2*i][2*j][c]     = v0;
      pix[2*i][2*j+1][c]   = v1;
      pix[2*i+1][2*j][c]   = v2;
      pix[2*i+1][2*j+1][c] = v3;
    end
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      data_in  = {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic configure(input int nc, input int nr, input bit m);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    en       = 1'b0;
    col      = 16'(nc);
    rows     = 16'(nr);
    mode     = m;
    @(posedge clk);
    #1;
    en = 1'b1;
  endtask

  // Drives up to 'limit' pixels of a frame. gap: 0 none, 1 alternate,
  // 2 random idle cycles between beats.
  task automatic run_frame(input int nc, input int nr, input bit m,
                           input int gap, input int limit);
    int   n;
    int   v;
    exp_t e;
    n = 0;
    for (int r = 0; r < nr; r++) begin
      for (int k = 0; k < nc; k++) begin
        if (n == limit) return;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        for (int c = 0; c < CH; c++) begin
          v = pix[r][k][c];
          data_in[c*DW +: DW] = v[DW-1:0];
        end
        if ((r % 2 == 1) && (k % 2 == 1)) begin
          e.data = pool_ref(r / 2, k / 2, m);
          e.pend = (r == nr - 1) && (k == nc - 1);
          e.cyc  = cyc + 1;
          sb.push_back(e);
        end
        n++;
        if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) idle(1);
      end
    end
  endtask

  // Monitor: every valid_out must match the next scoreboard entry.
  always @(negedge clk) begin
    if (valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 128'(valid_out), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_out", 128'(data_out), 128'(e.data));
        check("pool_end", 128'(pool_end), 128'(e.pend));
        check("latency_cycle", 128'(cyc), 128'(e.cyc));
      end
    end else if (pool_end) begin
      check("stray_pool_end", 128'(pool_end), 128'(0));
    end
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 1'b0;
    col      = 16'd4;
    rows     = 16'd4;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_out", 128'(data_out), 128'(0));
    check("reset_valid_out", 128'(valid_out), 128'(0));
    check("reset_pool_end", 128'(pool_end), 128'(0));
    rst_n = 1'b1;

    // Max pooling, 16x16 ramp, back-to-back.
    configure(16, 16, 1'b0);
    fill_ramp(16, 16);
    run_frame(16, 16, 1'b0, 0, -1);
    idle(4);

    // Avg corner windows: {-1,-2,-3,-4} and {127 x4}, then {-128 x4}.
    configure(4, 2, 1'b1);
    fill_window(0, 0, -1, -2, -3, -4);
    fill_window(0, 1, 127, 127, 127, 127);
    run_frame(4, 2, 1'b1, 0, -1);
    idle(2);
    fill_window(0, 0, -128, -128, -128, -128);
    fill_window(0, 1, -128, -128, -128, -128);
    run_frame(4, 2, 1'b1, 0, -1);
    idle(2);

    // 4x4 with alternating gaps, then the same pixels back-to-back.
    configure(4, 4, 1'b0);
    fill_random(4, 4);
    run_frame(4, 4, 1'b0, 1, -1);
    idle(2);
    run_frame(4, 4, 1'b0, 0, -1);
    idle(2);

    // Avg, random gaps.
    configure(4, 4, 1'b1);
    fill_random(4, 4);
    run_frame(4, 4, 1'b1, 2, -1);
    idle(2);

    // Two frames back-to-back, 8x4, different data.
    configure(8, 4, 1'b1);
    fill_random(4, 8);
    run_frame(8, 4, 1'b1, 0, -1);
    fill_random(4, 8);
    run_frame(8, 4, 1'b1, 0, -1);
    idle(2);
    configure(8, 4, 1'b0);
    fill_random(4, 8);
    run_frame(8, 4, 1'b0, 0, -1);
    fill_random(4, 8);
    run_frame(8, 4, 1'b0, 2, -1);
    idle(2);

    // Reset after 10 pixels, then a fresh frame.
    configure(4, 4, 1'b0);
    fill_random(4, 4);
    run_frame(4, 4, 1'b0, 0, 10);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset_data_out", 128'(data_out), 128'(0));
    check("midreset_valid_out", 128'(valid_out), 128'(0));
    fill_random(4, 4);
    run_frame(4, 4, 1'b0, 0, -1);
    idle(2);

    // en dropped after 6 pixels while valid_in keeps toggling, then a full frame.
    configure(4, 4, 1'b1);
    fill_random(4, 4);
    run_frame(4, 4, 1'b1, 0, 6);
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      valid_in = (i % 2 == 0);
      data_in  = {$urandom, $urandom, $urandom};
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    en       = 1'b1;
    fill_random(4, 4);
    run_frame(4, 4, 1'b1, 0, -1);
    idle(2);

    // Drain with a bounded wait.
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
